// File: rtl/uart_axis_tx.sv
// AXI-stream to UART transmitter: bytes are queued in a FIFO and sent
// as start/data/parity/stop frames on a registered, idle-high txd line.
module uart_axis_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic                            txd,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic [CW-1:0]         baud_q, baud_d;
  logic [IW-1:0]         bit_q, bit_d;
  logic                  txd_q, txd_d;
  logic                  full, empty;
  logic                  push, pop;
  logic                  baud_wrap;
  logic [DATA_WIDTH-1:0] head;

  assign full          = (level_q == LW'(FIFO_DEPTH));
  assign empty         = (level_q == '0);
  assign s_axis_tready = !full && !rst;
  assign push          = s_axis_tvalid && s_axis_tready;
  assign baud_wrap     = (baud_q == CW'(CLKS_PER_BIT - 1));
  assign head          = mem_q[rd_ptr_q];

  assign txd        = txd_q;
  assign busy       = (state_q != IDLE) || !empty;
  assign fifo_level = level_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_axis_tdata;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  // txd_d is derived from the current state, so the line trails the FSM
  // by one cycle; every bit still lasts exactly CLKS_PER_BIT cycles.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    txd_d   = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = (^head) ^ (PARITY_ODD != 0);
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        txd_d  = 1'b0;
        baud_d = baud_q + CW'(1);
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        txd_d  = shift_q[0];
        baud_d = baud_q + CW'(1);
        if (baud_wrap) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == IW'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + IW'(1);
          end
        end
      end
      PARITY: begin
        txd_d  = par_q;
        baud_d = baud_q + CW'(1);
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        txd_d  = 1'b1;
        baud_d = baud_q + CW'(1);
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == IW'(STOP_BITS - 1)) begin
            bit_d = '0;
            if (!empty) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = (^head) ^ (PARITY_ODD != 0);
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      txd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      txd_q    <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_axis_tx.sv
// Bench for uart_axis_tx: three configurations checked cycle by cycle
// against a frame-timeline model of the serial line and FIFO.
module tb_uart_axis_tx;

  localparam int CPB = 4;
  localparam int NF  = 128;
  localparam int PE [3] = '{0, 1, 1};
  localparam int PO [3] = '{0, 0, 1};
  localparam int SB [3] = '{1, 2, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tdata  [3];
  logic       tvalid [3];
  logic       tready [3];
  logic       txd    [3];
  logic       busy   [3];
  logic [4:0] lvl    [3];

  int cyc    = 0;
  int checks = 0;
  int passes = 0;

  int         ac [3][NF];
  int         st [3][NF];
  logic [7:0] by [3][NF];
  int         nacc [3];
  int         nf   [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_axis_tx #(
      .DATA_WIDTH  (8),
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (16),
      .PARITY_EN   (PE[g]),
      .PARITY_ODD  (PO[g]),
      .STOP_BITS   (SB[g])
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .s_axis_tdata (tdata[g]),
      .s_axis_tvalid(tvalid[g]),
      .s_axis_tready(tready[g]),
      .txd          (txd[g]),
      .busy         (busy[g]),
      .fifo_level   (lvl[g])
    );
  end

  function automatic int flen(int s);
    return (9 + PE[s] + SB[s]) * CPB;
  endfunction

  function automatic logic fbit(int s, logic [7:0] b, int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PE[s] != 0 && k == 9) return (^b) ^ (PO[s] != 0);
    return 1'b1;
  endfunction

  // Expected {txd, busy, tready, level} after edge t. A byte accepted at
  // edge N starts its frame at max(N+2, end of previous frame).
  function automatic logic [7:0] m_obs(int s, int t);
    int   lv;
    logic bz;
    logic ln;
    lv = 0;
    bz = 1'b0;
    ln = 1'b1;
    for (int i = 0; i < nacc[s]; i++) begin
      if (ac[s][i] <= t) lv++;
      if (st[s][i] - 1 <= t) lv--;
      if (t >= st[s][i] - 1 && t <= st[s][i] + flen(s) - 2) bz = 1'b1;
      if (t >= st[s][i] && t < st[s][i] + flen(s))
        ln = fbit(s, by[s][i], (t - st[s][i]) / CPB);
    end
    if (lv != 0) bz = 1'b1;
    return {ln, bz, lv < 16, lv[4:0]};
  endfunction

  task automatic clear_model();
    for (int s = 0; s < 3; s++) begin
      nacc[s] = 0;
      nf[s]   = 0;
    end
  endtask

  task automatic drive(input int s, input logic v, input logic [7:0] d,
                       output logic acc);
    logic [7:0] o;
    o = m_obs(s, cyc);
    tvalid[s] = v;
    tdata[s]  = v ? d : 8'($urandom);
    acc = v && o[5];
    if (acc && nacc[s] < NF) begin
      ac[s][nacc[s]] = cyc + 1;
      st[s][nacc[s]] = (cyc + 3 > nf[s]) ? cyc + 3 : nf[s];
      by[s][nacc[s]] = d;
      nf[s] = st[s][nacc[s]] + flen(s);
      nacc[s]++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] got;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      got = {txd[s], busy[s], tready[s], lvl[s]};
      checks++;
      if (got !== 8'b1000_0000)
        $display("FAIL reset_hold dut%0d: got %b want %b", s, got, 8'b1000_0000);
      else passes++;
    end
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      got = {txd[s], busy[s], tready[s], lvl[s]};
      checks++;
      if (got !== 8'b1010_0000)
        $display("FAIL reset_release dut%0d: got %b want %b", s, got, 8'b1010_0000);
      else passes++;
    end
  endtask

  task automatic test_single();
    logic [7:0] got, want;
    logic acc;
    int n, first0;
    n = cyc + 1;
    first0 = -1;
    drive(0, 1'b1, 8'h55, acc);
    @(negedge clk);
    for (int c = 0; c < 60; c++) begin
      got = {txd[0], busy[0], tready[0], lvl[0]};
      want = m_obs(0, cyc);
      checks++;
      if (got !== want)
        $display("FAIL single cyc %0d: got %b want %b", cyc, got, want);
      else passes++;
      if (txd[0] === 1'b0 && first0 < 0) first0 = cyc;
      drive(0, 1'b0, 8'h00, acc);
      @(negedge clk);
    end
    checks++;
    if (first0 != n + 2)
      $display("FAIL start_latency: got edge %0d want %0d", first0, n + 2);
    else passes++;
  endtask

  task automatic test_parity();
    logic [7:0] got, want;
    logic acc, pbit;
    int n;
    for (int s = 1; s < 3; s++) begin
      n = cyc + 1;
      pbit = 1'bx;
      drive(s, 1'b1, 8'h07, acc);
      @(negedge clk);
      for (int c = 0; c < 60; c++) begin
        got = {txd[s], busy[s], tready[s], lvl[s]};
        want = m_obs(s, cyc);
        checks++;
        if (got !== want)
          $display("FAIL parity dut%0d cyc %0d: got %b want %b", s, cyc, got, want);
        else passes++;
        if (cyc == n + 2 + 9 * CPB + 1) pbit = txd[s];
        drive(s, 1'b0, 8'h00, acc);
        @(negedge clk);
      end
      checks++;
      if (pbit !== (s == 1))
        $display("FAIL parity_bit dut%0d: got %b want %b", s, pbit, s == 1);
      else passes++;
    end
  endtask

  task automatic test_stream();
    logic [7:0] got, want;
    logic acc;
    int idx;
    bit saw_full;
    idx = 0;
    saw_full = 1'b0;
    for (int c = 0; c < 900; c++) begin
      got = {txd[0], busy[0], tready[0], lvl[0]};
      want = m_obs(0, cyc);
      checks++;
      if (got !== want)
        $display("FAIL stream cyc %0d: got %b want %b", cyc, got, want);
      else passes++;
      if (lvl[0] == 5'd16 && tready[0] === 1'b0) saw_full = 1'b1;
      drive(0, idx < 20, 8'(idx), acc);
      if (acc) idx++;
      @(negedge clk);
    end
    checks++;
    if (!saw_full)
      $display("FAIL stream_full: got no full stall want stall at 16");
    else passes++;
    checks++;
    if (idx != 20)
      $display("FAIL stream_count: got %0d want 20", idx);
    else passes++;
  endtask

  task automatic test_stop2();
    logic [7:0] got, want;
    logic acc;
    int run, gap;
    bit seen_low;
    run = 0;
    gap = -1;
    seen_low = 1'b0;
    drive(1, 1'b1, 8'h00, acc);
    @(negedge clk);
    for (int c = 0; c < 110; c++) begin
      got = {txd[1], busy[1], tready[1], lvl[1]};
      want = m_obs(1, cyc);
      checks++;
      if (got !== want)
        $display("FAIL stop2 cyc %0d: got %b want %b", cyc, got, want);
      else passes++;
      if (txd[1] === 1'b1) run++;
      else begin
        if (seen_low && run > 0) gap = run;
        seen_low = 1'b1;
        run = 0;
      end
      drive(1, c == 0, 8'h00, acc);
      @(negedge clk);
    end
    checks++;
    if (gap != 8)
      $display("FAIL stop2_gap: got %0d want 8", gap);
    else passes++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] got, want;
    logic acc;
    drive(0, 1'b1, 8'hA3, acc);
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      got = {txd[0], busy[0], tready[0], lvl[0]};
      want = m_obs(0, cyc);
      checks++;
      if (got !== want)
        $display("FAIL pre_reset cyc %0d: got %b want %b", cyc, got, want);
      else passes++;
      drive(0, c < 3, 8'($urandom), acc);
      @(negedge clk);
    end
    checks++;
    if (lvl[0] !== 5'd3)
      $display("FAIL queued_before_reset: got %0d want 3", lvl[0]);
    else passes++;
    rst = 1'b1;
    #1;
    got = {txd[0], busy[0], tready[0], lvl[0]};
    checks++;
    if (got !== 8'b1000_0000)
      $display("FAIL reset_mid: got %b want %b", got, 8'b1000_0000);
    else passes++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    #1;
    got = {txd[0], busy[0], tready[0], lvl[0]};
    checks++;
    if (got !== 8'b1010_0000)
      $display("FAIL reset_mid_release: got %b want %b", got, 8'b1010_0000);
    else passes++;
    drive(0, 1'b1, 8'h3C, acc);
    @(negedge clk);
    for (int c = 0; c < 60; c++) begin
      got = {txd[0], busy[0], tready[0], lvl[0]};
      want = m_obs(0, cyc);
      checks++;
      if (got !== want)
        $display("FAIL post_reset cyc %0d: got %b want %b", cyc, got, want);
      else passes++;
      drive(0, 1'b0, 8'h00, acc);
      @(negedge clk);
    end
  endtask

  task automatic test_push_pop();
    logic [7:0] got, want;
    logic acc;
    drive(0, 1'b1, 8'($urandom), acc);
    @(negedge clk);
    got = {txd[0], busy[0], tready[0], lvl[0]};
    want = m_obs(0, cyc);
    checks++;
    if (got !== want)
      $display("FAIL push_pop_first: got %b want %b", got, want);
    else passes++;
    drive(0, 1'b1, 8'($urandom), acc);
    @(negedge clk);
    checks++;
    if (lvl[0] !== 5'd1)
      $display("FAIL push_pop_level: got %0d want 1", lvl[0]);
    else passes++;
    for (int c = 0; c < 100; c++) begin
      got = {txd[0], busy[0], tready[0], lvl[0]};
      want = m_obs(0, cyc);
      checks++;
      if (got !== want)
        $display("FAIL push_pop cyc %0d: got %b want %b", cyc, got, want);
      else passes++;
      drive(0, 1'b0, 8'h00, acc);
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [7:0] got, want;
    logic acc;
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 1100; c++) begin
        got = {txd[s], busy[s], tready[s], lvl[s]};
        want = m_obs(s, cyc);
        checks++;
        if (got !== want)
          $display("FAIL random dut%0d cyc %0d: got %b want %b", s, cyc, got, want);
        else passes++;
        drive(s, c < 200 && $urandom_range(0, 7) == 0, 8'($urandom), acc);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      tvalid[s] = 1'b0;
      tdata[s]  = 8'h00;
    end
    clear_model();
    test_reset();
    test_single();
    test_parity();
    test_stream();
    test_stop2();
    test_reset_mid();
    test_push_pop();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
